// File: rtl/gat_pkg.sv
// Shared types and constants for the GAT host/core bridge.
package gat_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_LOADING = 3'd1,
    ST_ARMED   = 3'd2,
    ST_RUN     = 3'd3,
    ST_DONE    = 3'd4
  } bridge_state_e;

  // Debug word field positions, counted down from the MSB.
  localparam int unsigned DBG_STATE_OFS = 0;
  localparam int unsigned DBG_LAYER_OFS = 3;
  localparam int unsigned DBG_ERR_OFS   = 4;
  localparam int unsigned DBG_RSVD_OFS  = 5;
  localparam int unsigned DBG_CNT_OFS   = 8;

endpackage

// File: rtl/gat_bram_bridge_if.sv
// Host write channels, core write ports and feature readback path of the bridge.
interface gat_bram_bridge_if #(
  parameter int unsigned TOP_WIDTH   = 32,
  parameter int unsigned NUM_LOAD_CH = 3,
  parameter int unsigned CH_ADDR_W   = 18,
  parameter int unsigned CH_DATA_W   = 20,
  parameter int unsigned FEAT_ADDR_W = 16,
  parameter int unsigned FEAT_DATA_W = 32
);

  logic [NUM_LOAD_CH*TOP_WIDTH-1:0]     ld_din;
  logic [NUM_LOAD_CH-1:0]               ld_ena;
  logic [NUM_LOAD_CH-1:0]               ld_wea;
  logic [NUM_LOAD_CH*(CH_ADDR_W+2)-1:0] ld_addra;
  logic [NUM_LOAD_CH*CH_DATA_W-1:0]     core_din;
  logic [NUM_LOAD_CH-1:0]               core_wea;
  logic [NUM_LOAD_CH*CH_ADDR_W-1:0]     core_addra;
  logic                                 feat_rd;
  logic [FEAT_ADDR_W+1:0]               feat_addrb;
  logic [FEAT_DATA_W-1:0]               feat_dout;
  logic                                 feat_valid;
  logic [FEAT_ADDR_W-1:0]               core_feat_addrb;
  logic [FEAT_DATA_W-1:0]               core_feat_dout;

  modport slave (
    input  ld_din, ld_ena, ld_wea, ld_addra, feat_rd, feat_addrb, core_feat_dout,
    output core_din, core_wea, core_addra, feat_dout, feat_valid, core_feat_addrb
  );

  modport master (
    output ld_din, ld_ena, ld_wea, ld_addra, feat_rd, feat_addrb, core_feat_dout,
    input  core_din, core_wea, core_addra, feat_dout, feat_valid, core_feat_addrb
  );

endinterface

// File: rtl/gat_bridge_wr_ch.sv
// One host write channel: byte->word address, data trim, gated write strobe.
module gat_bridge_wr_ch #(
  parameter int unsigned TOP_WIDTH = 32,
  parameter int unsigned CH_ADDR_W = 18,
  parameter int unsigned CH_DATA_W = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic                 we_i,
  input  logic                 allowed_i,
  input  logic [TOP_WIDTH-1:0] din_i,
  input  logic [CH_ADDR_W+1:0] addr_i,
  output logic [CH_DATA_W-1:0] core_din_o,
  output logic                 core_wea_o,
  output logic [CH_ADDR_W-1:0] core_addra_o
);

  logic [CH_DATA_W-1:0] din_q;
  logic [CH_ADDR_W-1:0] addr_q;
  logic                 wea_q;

  logic unused_bits;
  assign unused_bits = ^{din_i[TOP_WIDTH-1:CH_DATA_W], addr_i[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_q  <= '0;
      addr_q <= '0;
      wea_q  <= 1'b0;
    end else begin
      din_q  <= din_i[CH_DATA_W-1:0];
      addr_q <= addr_i[CH_ADDR_W+1:2];
      wea_q  <= en_i & we_i & allowed_i;
    end
  end

  assign core_din_o   = din_q;
  assign core_addra_o = addr_q;
  assign core_wea_o   = wea_q;

endmodule

// File: rtl/gat_bram_bridge.sv
// Host-to-core bridge and run sequencer for the GAT accelerator:
// load tracking, start/done sequencing, watchdog and gated feature readback.
module gat_bram_bridge
  import gat_pkg::*;
#(
  parameter int unsigned TOP_WIDTH   = 32,
  parameter int unsigned NUM_LOAD_CH = 3,
  parameter int unsigned CH_ADDR_W   = 18,
  parameter int unsigned CH_DATA_W   = 20,
  parameter int unsigned FEAT_ADDR_W = 16,
  parameter int unsigned FEAT_DATA_W = 32,
  parameter int unsigned RD_LATENCY  = 2,
  parameter int unsigned TIMEOUT_W   = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   gat_layer,
  input  logic [NUM_LOAD_CH-1:0] load_done,
  output logic                   gat_ready,
  output logic                   gat_error,
  output logic [TOP_WIDTH-1:0]   gat_debug,
  output logic                   core_start,
  output logic                   core_layer,
  input  logic                   core_done,
  gat_bram_bridge_if.slave       bus
);

  localparam int unsigned CNT_W = TOP_WIDTH - 8;

  bridge_state_e        state_q;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, nwr;
  logic [CNT_W:0]       cnt_sum;
  logic                 err_q, start_q, layer_q, ready_q;
  logic [NUM_LOAD_CH-1:0] wr_req;
  logic                 write_allowed, any_wr, accepted, timeout;

  logic [RD_LATENCY:0]    vld_q, gate_q;
  logic [FEAT_ADDR_W-1:0] raddr_q;
  logic [FEAT_DATA_W-1:0] fdout_q;
  logic                   fvalid_q;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^bus.feat_addrb[1:0];

  always_comb begin
    wr_req        = bus.ld_ena & bus.ld_wea;
    write_allowed = state_q inside {ST_IDLE, ST_LOADING, ST_DONE};
    any_wr        = |wr_req;
    accepted      = any_wr & write_allowed;
    nwr           = '0;
    if (write_allowed) begin
      for (int unsigned c = 0; c < NUM_LOAD_CH; c++) begin
        nwr = nwr + CNT_W'(wr_req[c]);
      end
    end
    cnt_sum = {1'b0, cnt_q} + {1'b0, nwr};
    cnt_d   = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    wd_d    = (wd_q == '1) ? wd_q : wd_q + TIMEOUT_W'(1);
    // Trips on the increment that would reach all-ones, so a silent core
    // spends exactly 2^TIMEOUT_W-1 cycles in RUN.
    timeout = (wd_d == '1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wd_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      layer_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accepted || (|load_done)) begin
            state_q <= ST_LOADING;
            cnt_q   <= nwr;
          end
        end
        ST_LOADING: begin
          cnt_q <= cnt_d;
          if (&load_done) state_q <= ST_ARMED;
        end
        ST_ARMED: begin
          state_q <= ST_RUN;
          start_q <= 1'b1;
          layer_q <= gat_layer;
          err_q   <= any_wr;
          wd_q    <= '0;
        end
        ST_RUN: begin
          wd_q <= wd_d;
          if (any_wr || (!core_done && timeout)) err_q <= 1'b1;
          if (core_done || timeout) begin
            state_q <= ST_DONE;
            wd_q    <= '0;
            ready_q <= 1'b1;
          end
        end
        ST_DONE: begin
          cnt_q <= cnt_d;
          if (accepted) begin
            state_q <= ST_LOADING;
            ready_q <= 1'b0;
          end else if (load_done == '0) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Each read carries a tag recording whether it was issued in DONE;
  // untagged reads still complete but return zero data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q    <= '0;
      gate_q   <= '0;
      raddr_q  <= '0;
      fdout_q  <= '0;
      fvalid_q <= 1'b0;
    end else begin
      if (bus.feat_rd) raddr_q <= bus.feat_addrb[FEAT_ADDR_W+1:2];
      vld_q    <= {vld_q[RD_LATENCY-1:0], bus.feat_rd};
      gate_q   <= {gate_q[RD_LATENCY-1:0], state_q == ST_DONE};
      fvalid_q <= vld_q[RD_LATENCY];
      if (vld_q[RD_LATENCY]) fdout_q <= gate_q[RD_LATENCY] ? bus.core_feat_dout : '0;
    end
  end

  for (genvar c = 0; c < NUM_LOAD_CH; c++) begin : g_ch
    gat_bridge_wr_ch #(
      .TOP_WIDTH(TOP_WIDTH),
      .CH_ADDR_W(CH_ADDR_W),
      .CH_DATA_W(CH_DATA_W)
    ) u_wr_ch (
      .clk          (clk),
      .rst          (rst),
      .en_i         (bus.ld_ena[c]),
      .we_i         (bus.ld_wea[c]),
      .allowed_i    (write_allowed),
      .din_i        (bus.ld_din[c*TOP_WIDTH +: TOP_WIDTH]),
      .addr_i       (bus.ld_addra[c*(CH_ADDR_W+2) +: CH_ADDR_W+2]),
      .core_din_o   (bus.core_din[c*CH_DATA_W +: CH_DATA_W]),
      .core_wea_o   (bus.core_wea[c]),
      .core_addra_o (bus.core_addra[c*CH_ADDR_W +: CH_ADDR_W])
    );
  end

  always_comb begin
    gat_debug = '0;
    gat_debug[TOP_WIDTH-1-DBG_STATE_OFS -: STATE_W] = state_q;
    gat_debug[TOP_WIDTH-1-DBG_LAYER_OFS]            = layer_q;
    gat_debug[TOP_WIDTH-1-DBG_ERR_OFS]              = err_q;
    gat_debug[TOP_WIDTH-1-DBG_CNT_OFS -: CNT_W]     = cnt_q;
  end

  assign gat_ready           = ready_q;
  assign gat_error           = err_q;
  assign core_start          = start_q;
  assign core_layer          = layer_q;
  assign bus.core_feat_addrb = raddr_q;
  assign bus.feat_dout       = fdout_q;
  assign bus.feat_valid      = fvalid_q;

endmodule

// File: tb/tb_gat_bram_bridge.sv
// Directed self-checking bench for gat_bram_bridge with a 2-cycle feature BRAM model.
module tb_gat_bram_bridge;

  localparam int unsigned TOP_WIDTH   = 32;
  localparam int unsigned NUM_LOAD_CH = 3;
  localparam int unsigned CH_ADDR_W   = 18;
  localparam int unsigned CH_DATA_W   = 20;
  localparam int unsigned FEAT_ADDR_W = 16;
  localparam int unsigned FEAT_DATA_W = 32;
  localparam int unsigned RD_LATENCY  = 2;
  localparam int unsigned TIMEOUT_W   = 4;

  logic clk = 1'b0;
  logic rst;
  logic gat_layer;
  logic [NUM_LOAD_CH-1:0] load_done;
  logic gat_ready, gat_error, core_start, core_layer, core_done;
  logic [TOP_WIDTH-1:0] gat_debug;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gat_bram_bridge_if #(
    .TOP_WIDTH(TOP_WIDTH), .NUM_LOAD_CH(NUM_LOAD_CH), .CH_ADDR_W(CH_ADDR_W),
    .CH_DATA_W(CH_DATA_W), .FEAT_ADDR_W(FEAT_ADDR_W), .FEAT_DATA_W(FEAT_DATA_W)
  ) bus ();

  gat_bram_bridge #(
    .TOP_WIDTH(TOP_WIDTH), .NUM_LOAD_CH(NUM_LOAD_CH), .CH_ADDR_W(CH_ADDR_W),
    .CH_DATA_W(CH_DATA_W), .FEAT_ADDR_W(FEAT_ADDR_W), .FEAT_DATA_W(FEAT_DATA_W),
    .RD_LATENCY(RD_LATENCY), .TIMEOUT_W(TIMEOUT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .gat_layer  (gat_layer),
    .load_done  (load_done),
    .gat_ready  (gat_ready),
    .gat_error  (gat_error),
    .gat_debug  (gat_debug),
    .core_start (core_start),
    .core_layer (core_layer),
    .core_done  (core_done),
    .bus        (bus)
  );

  // Feature BRAM: two-cycle read, content = {16'hC0DE, word address}.
  logic [FEAT_DATA_W-1:0] bram_pipe_q;
  always @(posedge clk) begin
    bram_pipe_q        <= {16'hC0DE, bus.core_feat_addrb};
    bus.core_feat_dout <= bram_pipe_q;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input logic [CH_ADDR_W+1:0] addr, input logic [TOP_WIDTH-1:0] din);
    bus.ld_ena[ch] = 1'b1;
    bus.ld_wea[ch] = 1'b1;
    bus.ld_addra[ch*(CH_ADDR_W+2) +: CH_ADDR_W+2] = addr;
    bus.ld_din[ch*TOP_WIDTH +: TOP_WIDTH] = din;
  endtask

  task automatic clr_wr();
    bus.ld_ena = '0;
    bus.ld_wea = '0;
  endtask

  int run_cycles;
  int extra_starts;

  initial begin
    rst            = 1'b1;
    gat_layer      = 1'b0;
    load_done      = '0;
    core_done      = 1'b0;
    bus.ld_din     = '0;
    bus.ld_ena     = '0;
    bus.ld_wea     = '0;
    bus.ld_addra   = '0;
    bus.feat_rd    = 1'b0;
    bus.feat_addrb = '0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("rst_debug", gat_debug, 32'h0);
    check("rst_ready", gat_ready, 1'b0);
    check("rst_start", core_start, 1'b0);
    check("rst_valid", bus.feat_valid, 1'b0);

    // First write moves IDLE->LOADING and counts itself.
    wr(1, 20'h0000C, 32'hABCDE123);
    tick();
    clr_wr();
    check("wr1_wea", bus.core_wea, 3'b010);
    check("wr1_addr", bus.core_addra[1*CH_ADDR_W +: CH_ADDR_W], 18'd3);
    check("wr1_din", bus.core_din[1*CH_DATA_W +: CH_DATA_W], 20'hDE123);
    check("wr1_debug", gat_debug, 32'h2000_0001);

    // Two channels at once, including the top host address.
    wr(0, 20'h00004, 32'h0000_0FFF);
    wr(2, 20'hFFFFF, 32'hFFFF_FFFF);
    tick();
    clr_wr();
    check("wr2_wea", bus.core_wea, 3'b101);
    check("wr2_addr0", bus.core_addra[0 +: CH_ADDR_W], 18'd1);
    check("wr2_addr2", bus.core_addra[2*CH_ADDR_W +: CH_ADDR_W], 18'h3FFFF);
    check("wr2_din2", bus.core_din[2*CH_DATA_W +: CH_DATA_W], 20'hFFFFF);
    check("wr2_debug", gat_debug, 32'h2000_0003);

    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check("done_ignored", gat_debug, 32'h2000_0003);

    gat_layer = 1'b1;
    load_done = 3'b011;
    tick();
    check("partial_load", gat_debug, 32'h2000_0003);

    load_done = 3'b111;
    tick();
    check("armed_debug", gat_debug, 32'h4000_0003);
    check("armed_start", core_start, 1'b0);
    tick();
    check("run_start", core_start, 1'b1);
    check("run_layer", core_layer, 1'b1);
    check("run_debug", gat_debug, 32'h7000_0003);

    wr(0, 20'h00008, 32'h55);
    tick();
    clr_wr();
    check("run_wr_wea", bus.core_wea, 3'b000);
    check("run_wr_err", gat_error, 1'b1);
    check("start_pulse", core_start, 1'b0);

    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check("done_ready", gat_ready, 1'b1);
    check("done_debug", gat_debug, 32'h9800_0003);

    // Three back-to-back reads in DONE.
    bus.feat_rd = 1'b1;
    bus.feat_addrb = 18'h10;
    tick();
    check("rd_addr0", bus.core_feat_addrb, 16'd4);
    bus.feat_addrb = 18'h14;
    tick();
    check("rd_addr1", bus.core_feat_addrb, 16'd5);
    bus.feat_addrb = 18'h18;
    tick();
    bus.feat_rd = 1'b0;
    check("rd_addr2", bus.core_feat_addrb, 16'd6);
    check("rd_early", bus.feat_valid, 1'b0);
    tick();
    check("rd_v0", bus.feat_valid, 1'b1);
    check("rd_d0", bus.feat_dout, 32'hC0DE_0004);
    tick();
    check("rd_v1", bus.feat_valid, 1'b1);
    check("rd_d1", bus.feat_dout, 32'hC0DE_0005);
    tick();
    check("rd_v2", bus.feat_valid, 1'b1);
    check("rd_d2", bus.feat_dout, 32'hC0DE_0006);
    tick();
    check("rd_end", bus.feat_valid, 1'b0);
    check("rd_hold", bus.feat_dout, 32'hC0DE_0006);

    load_done = 3'b000;
    tick();
    check("idle_debug", gat_debug, 32'h1800_0003);
    check("idle_ready", gat_ready, 1'b0);

    // Read outside DONE completes with zero data.
    bus.feat_rd = 1'b1;
    bus.feat_addrb = 18'h10;
    tick();
    bus.feat_rd = 1'b0;
    tick();
    tick();
    check("idle_rd_early", bus.feat_valid, 1'b0);
    tick();
    check("idle_rd_valid", bus.feat_valid, 1'b1);
    check("idle_rd_data", bus.feat_dout, 32'h0);

    gat_layer = 1'b0;
    wr(2, 20'h00040, 32'h0001_2345);
    tick();
    clr_wr();
    check("reload_addr", bus.core_addra[2*CH_ADDR_W +: CH_ADDR_W], 18'h10);
    check("reload_din", bus.core_din[2*CH_DATA_W +: CH_DATA_W], 20'h12345);
    check("reload_debug", gat_debug, 32'h3800_0001);
    load_done = 3'b111;
    tick();
    tick();
    check("rerun_start", core_start, 1'b1);
    check("rerun_err", gat_error, 1'b0);
    check("rerun_layer", core_layer, 1'b0);

    // No core_done: watchdog must end the run.
    run_cycles   = 1;
    extra_starts = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (core_start) extra_starts++;
      if (gat_debug[31:29] == 3'd3) run_cycles++;
      else break;
    end
    check("wd_cycles", run_cycles, 15);
    check("wd_state", gat_debug[31:29], 3'd4);
    check("wd_err", gat_error, 1'b1);
    check("wd_ready", gat_ready, 1'b1);
    check("wd_single_start", extra_starts, 0);

    // Relaunch from DONE, then reset while a read is in flight.
    wr(0, 20'h0, 32'h1);
    tick();
    clr_wr();
    tick();
    bus.feat_rd = 1'b1;
    bus.feat_addrb = 18'h20;
    tick();
    bus.feat_rd = 1'b0;
    check("rst_pre_start", core_start, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    check("arst_debug", gat_debug, 32'h0);
    check("arst_start", core_start, 1'b0);
    check("arst_layer_err", {core_layer, gat_error, gat_ready}, 3'b000);
    check("arst_addrb", bus.core_feat_addrb, 16'd0);
    load_done = 3'b000;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("arst_rd_drop", bus.feat_valid, 1'b0);
    check("arst_idle", gat_debug, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
